ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), meaning the shift-amount width; it is derived and not overridden.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-007 SHALL have port op  input  5  operation code, encoded as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
REQ-008 SHALL have ports src_a, src_b  input  XLEN  operands.
REQ-009 SHALL have port flush  input  1  kills any in-flight or held operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_result  output  XLEN  registered result.
REQ-013 SHALL have ports out_zero, out_lt, out_ltu  output  1 each: result==0, signed src_a<src_b, unsigned src_a<src_b; lt/ltu are captured at accept.

Function
REQ-014 SHALL implement the FSM states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-015 SHALL accept an operation on the cycle T where in_valid && in_ready && !flush; src_a, src_b and op are latched at T.
REQ-016 Ops 0-9 SHALL go IDLE->DONE with out_valid=1 at T+1; results per RV32I semantics; shifts SHALL use src_b[SHW-1:0]; SLT/SLTU SHALL zero-extend to XLEN.
REQ-017 Ops >17 SHALL produce result 0 with out_valid at T+1.
REQ-018 Ops 10-13 SHALL run a radix-2 shift-add over operand magnitudes for exactly XLEN cycles in MUL, then enter DONE; out_valid SHALL assert at T+XLEN+1.
REQ-019 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits for signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-020 Ops 14-17 SHALL run a restoring divide over magnitudes for exactly XLEN cycles in DIV, then enter DONE; out_valid SHALL assert at T+XLEN+1.
REQ-021 Divide signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-022 Divide by zero SHALL skip DIV and reach DONE at T+1: DIV/DIVU return all-ones; REM/REMU return src_a.
REQ-023 Signed overflow (src_a = most-negative value, src_b = -1) on DIV/REM SHALL reach DONE at T+1: DIV returns src_a; REM returns 0.
REQ-024 In DONE, out_valid=1 and out_result and the flags SHALL be held stable until out_valid && out_ready; on that cycle the FSM returns to IDLE, with in_ready=1 the next cycle.
REQ-025 flush=1 in any state SHALL force IDLE on the next edge with out_valid=0; flush with in_valid in IDLE SHALL accept nothing.
REQ-026 There SHALL be no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-027 reset=1 SHALL force IDLE, the iteration counter to 0, out_valid=0, out_result=0 and all flags=0 on the next edge; reset SHALL have priority over flush and over accept.
REQ-028 reset asserted mid-MUL/DIV SHALL discard the operation; no out_valid SHALL follow.

Verification (XLEN=32)
REQ-029 ADD 5,7 accepted at T -> out_valid at T+1, out_result=12, out_zero=0; SUB 7,7 -> 0, out_zero=1.
REQ-030 MULH 0x80000000,0x80000000 -> out_valid at T+33, result 0x40000000; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV 0xFFFFFFF9(-7),2 -> 0xFFFFFFFD at T+33; REM of the same operands -> 0xFFFFFFFF.
REQ-032 DIVU 7,0 -> 0xFFFFFFFF at T+1; REM 0x80000000,0xFFFFFFFF -> 0 at T+1.
REQ-033 out_ready held low for 3 cycles in DONE -> out_result stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-034 flush at T+10 of a DIVU (and, separately, reset at T+10) -> out_valid never asserts and in_ready=1 at T+11.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Execute unit: single-cycle ALU ops plus iterative multiply (shift-add) and
// restoring divide, both running over operand magnitudes for XLEN cycles.
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_lt,
  output logic            out_ltu
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW:0]    LAST_CNT = (SHW+1)'(XLEN-1);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_reg, state_next;
  logic [SHW:0]        cnt_reg;
  logic [4:0]          op_reg;
  logic [XLEN-1:0]     acc_reg, lo_reg, mag_b_reg, result_reg;
  logic                neg_reg, neg_rem_reg, zero_reg, lt_reg, ltu_reg;

  logic                is_mul, is_div, a_neg, b_neg, div_zero, div_ovf, go_iter;
  logic                lt_now, ltu_now, last_iter;
  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     mag_a, mag_b, fast_result;

  assign is_mul   = (op >= OP_MUL) && (op <= OP_MULHU);
  assign is_div   = (op >= OP_DIV) && (op <= OP_REMU);
  assign a_neg    = (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src_a[XLEN-1];
  assign b_neg    = (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && src_b[XLEN-1];
  assign mag_a    = a_neg ? -src_a : src_a;
  assign mag_b    = b_neg ? -src_b : src_b;
  assign div_zero = (src_b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (src_a == MIN_VAL) && (src_b == '1);
  assign go_iter  = is_mul || (is_div && !div_zero && !div_ovf);
  assign lt_now   = $signed(src_a) < $signed(src_b);
  assign ltu_now  = src_a < src_b;
  assign shamt    = src_b[SHW-1:0];

  // Divide special cases are resolved here so they finish in one cycle.
  always_comb begin
    fast_result = '0;
    case (op)
      OP_ADD:           fast_result = src_a + src_b;
      OP_SUB:           fast_result = src_a - src_b;
      OP_AND:           fast_result = src_a & src_b;
      OP_OR:            fast_result = src_a | src_b;
      OP_XOR:           fast_result = src_a ^ src_b;
      OP_SLL:           fast_result = src_a << shamt;
      OP_SRL:           fast_result = src_a >> shamt;
      OP_SRA:           fast_result = $signed(src_a) >>> shamt;
      OP_SLT:           fast_result = {{(XLEN-1){1'b0}}, lt_now};
      OP_SLTU:          fast_result = {{(XLEN-1){1'b0}}, ltu_now};
      OP_DIV, OP_DIVU:  fast_result = div_zero ? '1 : src_a;
      OP_REM, OP_REMU:  fast_result = div_zero ? src_a : '0;
      default:          fast_result = '0;
    endcase
  end

  // One iteration step of each engine; acc holds product-high / partial remainder.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok, unused_bits;
  logic [XLEN-1:0]   mul_acc, mul_lo, div_acc, div_lo, step_acc, step_lo;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quo, rem, iter_result;

  assign mul_sum     = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, mag_b_reg} : '0);
  assign mul_acc     = mul_sum[XLEN:1];
  assign mul_lo      = {mul_sum[0], lo_reg[XLEN-1:1]};
  assign div_shift   = {acc_reg, lo_reg[XLEN-1]};
  assign div_diff    = {1'b0, div_shift} - {2'b00, mag_b_reg};
  assign div_ok      = !div_diff[XLEN+1];
  assign div_acc     = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo      = {lo_reg[XLEN-2:0], div_ok};
  assign unused_bits = div_diff[XLEN];
  assign step_acc    = (state_reg == MUL) ? mul_acc : div_acc;
  assign step_lo     = (state_reg == MUL) ? mul_lo : div_lo;
  assign prod_mag    = {mul_acc, mul_lo};
  assign prod        = neg_reg ? -prod_mag : prod_mag;
  assign quo         = neg_reg ? -div_lo : div_lo;
  assign rem         = neg_rem_reg ? -div_acc : div_acc;
  assign last_iter   = (cnt_reg == LAST_CNT);

  always_comb begin
    iter_result = '0;
    case (op_reg)
      OP_MUL:                        iter_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  iter_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               iter_result = quo;
      OP_REM, OP_REMU:               iter_result = rem;
      default:                       iter_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) state_next = is_mul ? MUL : (go_iter ? DIV : DONE);
        MUL:  if (last_iter) state_next = DONE;
        DIV:  if (last_iter) state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      op_reg      <= '0;
      acc_reg     <= '0;
      lo_reg      <= '0;
      mag_b_reg   <= '0;
      neg_reg     <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      lt_reg      <= 1'b0;
      ltu_reg     <= 1'b0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          op_reg      <= op;
          lt_reg      <= lt_now;
          ltu_reg     <= ltu_now;
          acc_reg     <= '0;
          lo_reg      <= mag_a;
          mag_b_reg   <= mag_b;
          neg_reg     <= a_neg ^ b_neg;
          neg_rem_reg <= a_neg;
          cnt_reg     <= '0;
          if (!go_iter) begin
            result_reg <= fast_result;
            zero_reg   <= (fast_result == '0);
          end
        end
        MUL, DIV: begin
          acc_reg <= step_acc;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg + CNT_ONE;
          if (last_iter) begin
            result_reg <= iter_result;
            zero_reg   <= (iter_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;
  assign out_zero   = zero_reg;
  assign out_lt     = lt_reg;
  assign out_ltu    = ltu_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (XLEN=32): reference results come from
// native SystemVerilog arithmetic, queued at issue and compared on completion.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] src_a, src_b, out_result;
  logic        out_zero, out_lt, out_ltu;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_lt(out_lt), .out_ltu(out_ltu)
  );

  typedef struct {
    logic [31:0] res;
    logic        z, lt, ltu;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic        [63:0] p;
    logic signed [31:0] qa, qb;
    logic               ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    qa = a;
    qb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'(qa >>> b[4:0]);
      5'd8:  return {31'b0, qa < qb};
      5'd9:  return {31'b0, a < b};
      5'd10: begin p = sa * sb; return p[31:0]; end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin p = sa * ub; return p[63:32]; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(qa / qb);
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(qa % qb);
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && ((o == 5'd14) || (o == 5'd16));
    if (o >= 5'd10 && o <= 5'd13) return 33;
    if (o >= 5'd14 && o <= 5'd17 && b != 0 && !ovf) return 33;
    return 1;
  endfunction

  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t e, got;
    int   lat;
    e.res = ref_result(o, a, b);
    e.z   = (e.res == 32'h0);
    e.lt  = $signed(a) < $signed(b);
    e.ltu = a < b;
    e.lat = ref_lat(o, a, b);
    sb_q.push_back(e);
    check({tag, "/in_ready_pre"}, 64'(in_ready), 64'(1));
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb_q.pop_front();
    check({tag, "/latency"}, 64'(lat), 64'(got.lat));
    check({tag, "/result"}, 64'(out_result), 64'(got.res));
    check({tag, "/zero"}, 64'(out_zero), 64'(got.z));
    check({tag, "/lt"}, 64'(out_lt), 64'(got.lt));
    check({tag, "/ltu"}, 64'(out_ltu), 64'(got.ltu));
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d", o, a, b, out_result, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "/hold_in_ready"}, 64'(in_ready), 64'(0));
      check({tag, "/hold_result"}, 64'(out_result), 64'(got.res));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/out_valid_post"}, 64'(out_valid), 64'(0));
    check({tag, "/in_ready_post"}, 64'(in_ready), 64'(1));
  endtask

  task automatic kill_test(input string tag, input bit use_reset);
    int seen;
    check({tag, "/in_ready_pre"}, 64'(in_ready), 64'(1));
    op = 5'd15; src_a = 32'd3; src_b = 32'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_reset) reset = 1'b1;
    else           flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    check({tag, "/in_ready_T11"}, 64'(in_ready), 64'(1));
    check({tag, "/out_valid_T11"}, 64'(out_valid), 64'(0));
    if (use_reset) begin
      check({tag, "/result_cleared"}, 64'(out_result), 64'(0));
      check({tag, "/ltu_cleared"}, 64'(out_ltu), 64'(0));
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check({tag, "/no_out_valid"}, 64'(seen), 64'(0));
    $display("%s: DIVU 3/100 killed at T+10, out_valid cycles=%0d", tag, seen);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset/in_ready", 64'(in_ready), 64'(1));
    check("reset/out_valid", 64'(out_valid), 64'(0));
    check("reset/result", 64'(out_result), 64'(0));
    check("reset/flags", 64'({out_zero, out_lt, out_ltu}), 64'(0));

    do_op("add",    5'd0,  32'd5,          32'd7,          0);
    do_op("sub",    5'd1,  32'd7,          32'd7,          0);
    do_op("and",    5'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  0);
    do_op("or",     5'd3,  32'hF000_0001,  32'h0000_0F10,  0);
    do_op("xor",    5'd4,  32'hAAAA_5555,  32'hFFFF_0000,  0);
    do_op("sll",    5'd5,  32'h8000_0003,  32'd33,         0);
    do_op("srl",    5'd6,  32'h8000_0000,  32'd31,         0);
    do_op("sra",    5'd7,  32'h8000_0010,  32'd4,          0);
    do_op("slt",    5'd8,  32'hFFFF_FFFF,  32'd1,          0);
    do_op("sltu",   5'd9,  32'hFFFF_FFFF,  32'd1,          0);
    do_op("badop",  5'd20, 32'd9,          32'd9,          0);
    do_op("mul",    5'd10, 32'hFFFF_FFFD,  32'd7,          0);
    do_op("mulh",   5'd11, 32'h8000_0000,  32'h8000_0000,  0);
    do_op("mulhsu", 5'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
    do_op("mulhu",  5'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
    do_op("div",    5'd14, 32'hFFFF_FFF9,  32'd2,          0);
    do_op("rem",    5'd16, 32'hFFFF_FFF9,  32'd2,          0);
    do_op("divu",   5'd15, 32'd100,        32'd7,          0);
    do_op("remu",   5'd17, 32'hFFFF_FFFF,  32'd10,         0);
    do_op("divu0",  5'd15, 32'd7,          32'd0,          0);
    do_op("remu0",  5'd17, 32'd7,          32'd0,          0);
    do_op("removf", 5'd16, 32'h8000_0000,  32'hFFFF_FFFF,  0);
    do_op("divovf", 5'd14, 32'h8000_0000,  32'hFFFF_FFFF,  0);
    do_op("hold",   5'd0,  32'd3,          32'd4,          3);

    // Offer and flush in the same IDLE cycle: nothing may be accepted.
    op = 5'd0; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush/out_valid", 64'(out_valid), 64'(0));
    check("idle_flush/in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check("idle_flush/out_valid_late", 64'(out_valid), 64'(0));
    $display("idle_flush: in_valid with flush, out_valid=%0d", out_valid);

    kill_test("flush_divu", 1'b0);
    kill_test("reset_divu", 1'b1);

    do_op("after_kill", 5'd13, 32'h0001_0000, 32'h0001_0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
